// File: rtl/ram_bist.sv
`default_nettype none
// ============================================================================
// Module   : ram_bist
// Purpose  : Built-in self-test initiator for a 16-bit single-port RAM.
//            Writes an LFSR pattern over addresses 0..last_addr, regenerates
//            the pattern, reads the range back and counts mismatches.
// Options  : RAM_BIST_FAIL_LOG_EN - capture address/data of first mismatch.
// Revision : 1.0 - initial release
// ============================================================================
module ram_bist #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic [15:0]   seed_i,
  input  logic [AW-1:0] last_addr_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          pass_o,
  output logic [AW:0]   err_cnt_o,
  output logic          ram_wr_o,
  output logic          ram_oe_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [15:0]   ram_din_o,
  input  logic [15:0]   ram_dout_i,
  output logic [AW-1:0] fail_addr_o,
  output logic [15:0]   fail_data_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_GAP   = 3'd2,
    S_READ  = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [15:0] C_ZERO_SEED_SUB = 16'hACE1;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] last_q, last_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [15:0]   seed_q, seed_d;
  logic [AW:0]   err_q, err_d;
  logic          pass_q, pass_d;
  logic          busy_q, done_q, ram_wr_q, ram_oe_q;
  logic [15:0]   ram_din_q;
  logic          cmp_q;
  logic [15:0]   exp_q;
  logic [15:0]   w_seed_eff;
  logic          w_accept;
  logic          w_mismatch;

  // Fibonacci LFSR, shifting left, taps 15/13/12/10
  function automatic logic [15:0] lfsr_step(input logic [15:0] d);
    lfsr_step = {d[14:0], d[15] ^ d[13] ^ d[12] ^ d[10]};
  endfunction

  // An all-zero seed would lock the LFSR, so substitute a fixed non-zero one
  assign w_seed_eff = (seed_i == 16'h0000) ? C_ZERO_SEED_SUB : seed_i;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state, address/pattern sequencing and result accumulation
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    last_d     = last_q;
    lfsr_d     = lfsr_q;
    seed_d     = seed_q;
    err_d      = err_q;
    pass_d     = pass_q;
    w_accept   = 1'b0;
    w_mismatch = cmp_q && (ram_dout_i != exp_q);
    if (w_mismatch) err_d = err_q + (AW+1)'(1);
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          w_accept = 1'b1;
          state_d  = S_WRITE;
          addr_d   = '0;
          lfsr_d   = w_seed_eff;
          seed_d   = w_seed_eff;
          last_d   = last_addr_i;
          err_d    = '0;
          pass_d   = 1'b0;
        end
      end
      S_WRITE: begin
        if (addr_q == last_q) begin
          // Rewind the pattern so the read pass regenerates word 0 onwards
          state_d = S_GAP;
          addr_d  = '0;
          lfsr_d  = seed_q;
        end else begin
          addr_d = addr_q + AW'(1);
          lfsr_d = lfsr_step(lfsr_q);
        end
      end
      S_GAP: state_d = S_READ;
      S_READ: begin
        if (addr_q == last_q) begin
          state_d = S_DRAIN;
        end else begin
          addr_d = addr_q + AW'(1);
          lfsr_d = lfsr_step(lfsr_q);
        end
      end
      S_DRAIN: begin
        // Final compare lands here, so the verdict includes it
        state_d = S_DONE;
        addr_d  = '0;
        pass_d  = (err_d == '0);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath registers and registered outputs decoded from the next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q    <= '0;
      last_q    <= '0;
      lfsr_q    <= '0;
      seed_q    <= '0;
      err_q     <= '0;
      pass_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ram_wr_q  <= 1'b0;
      ram_oe_q  <= 1'b0;
      ram_din_q <= '0;
      cmp_q     <= 1'b0;
      exp_q     <= '0;
    end else begin
      addr_q    <= addr_d;
      last_q    <= last_d;
      lfsr_q    <= lfsr_d;
      seed_q    <= seed_d;
      err_q     <= err_d;
      pass_q    <= pass_d;
      busy_q    <= (state_d == S_WRITE) || (state_d == S_GAP) ||
                   (state_d == S_READ)  || (state_d == S_DRAIN);
      done_q    <= (state_d == S_DONE);
      ram_wr_q  <= (state_d == S_WRITE);
      ram_oe_q  <= (state_d == S_READ) || (state_d == S_DRAIN);
      ram_din_q <= (state_d == S_WRITE) ? lfsr_d : 16'h0000;
      // RAM read latency is one cycle: delay the expected word to match
      cmp_q     <= (state_q == S_READ);
      exp_q     <= lfsr_q;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign pass_o     = pass_q;
  assign err_cnt_o  = err_q;
  assign ram_wr_o   = ram_wr_q;
  assign ram_oe_o   = ram_oe_q;
  assign ram_addr_o = addr_q;
  assign ram_din_o  = ram_din_q;

`ifdef RAM_BIST_FAIL_LOG_EN
  logic [AW-1:0] cmp_addr_q;
  logic [AW-1:0] fail_addr_q;
  logic [15:0]   fail_data_q;

  // Remember the first mismatching address/data of a run
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmp_addr_q  <= '0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
    end else begin
      cmp_addr_q <= addr_q;
      if (w_accept) begin
        fail_addr_q <= '0;
        fail_data_q <= '0;
      end else if (w_mismatch && (err_q == '0)) begin
        fail_addr_q <= cmp_addr_q;
        fail_data_q <= ram_dout_i;
      end
    end
  end

  assign fail_addr_o = fail_addr_q;
  assign fail_data_o = fail_data_q;
`else
  assign fail_addr_o = '0;
  assign fail_data_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_bist.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_bist
// Purpose  : Directed self-checking bench for ram_bist with a behavioural
//            1-cycle-latency RAM that can model address bit 3 stuck at 0.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_bist;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [15:0]   seed = 16'h0;
  logic [AW-1:0] last = '0;
  logic          busy, done, pass, ram_wr, ram_oe;
  logic [AW:0]   err_cnt;
  logic [AW-1:0] ram_addr, fail_addr;
  logic [15:0]   ram_din, ram_dout, fail_data;

  logic [15:0]   mem [0:255];
  logic [15:0]   rd_q = 16'h0;
  logic          stuck3 = 1'b0;
  logic [AW-1:0] eff_addr;

  int checks = 0;
  int errors = 0;
  int busy_cnt;
  int done_cyc;
  logic [15:0] wlog [0:255];

  ram_bist #(.AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .seed_i(seed),
    .last_addr_i(last), .busy_o(busy), .done_o(done), .pass_o(pass),
    .err_cnt_o(err_cnt), .ram_wr_o(ram_wr), .ram_oe_o(ram_oe),
    .ram_addr_o(ram_addr), .ram_din_o(ram_din), .ram_dout_i(ram_dout),
    .fail_addr_o(fail_addr), .fail_data_o(fail_data)
  );

  always #5 clk = ~clk;

  // Behavioural RAM, read latency 1, optional address bit 3 fault
  assign eff_addr = stuck3 ? (ram_addr & 8'hF7) : ram_addr;
  always @(posedge clk) begin
    if (ram_wr) mem[eff_addr] <= ram_din;
    rd_q <= mem[eff_addr];
  end
  assign ram_dout = ram_oe ? rd_q : 16'h0000;

  // Launch a run and count cycles until done; ends at the negedge of done
  task automatic run(input logic [15:0] s, input logic [AW-1:0] la,
                     input bit hold, input int limit);
    @(negedge clk);
    seed = s; last = la; start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    busy_cnt = 0; done_cyc = 0;
    for (int c = 1; c <= limit && done_cyc == 0; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (ram_wr) wlog[ram_addr] = ram_din;
      if (done) done_cyc = c;
    end
    checks++;
    if (done_cyc == 0) begin
      errors++;
      $display("FAIL run_timeout: done not seen within %0d cycles (seed %h last %0d)", limit, s, la);
    end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({busy, done, pass, ram_wr, ram_oe} !== 5'b0 || err_cnt !== '0 ||
        ram_addr !== '0 || ram_din !== 16'h0 || fail_addr !== '0 || fail_data !== 16'h0) begin
      errors++;
      $display("FAIL %s: busy=%b done=%b pass=%b wr=%b oe=%b err=%0d addr=%h din=%h fa=%h fd=%h, required all 0",
               tag, busy, done, pass, ram_wr, ram_oe, err_cnt, ram_addr, ram_din, fail_addr, fail_data);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset_outputs");
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [15:0] exp_w;
    run(16'h0001, 8'd9, 1'b0, 40);
    checks++; if (done_cyc !== 23) begin errors++; $display("FAIL basic_done_cycle: got %0d required 23", done_cyc); end
    checks++; if (busy_cnt !== 22) begin errors++; $display("FAIL basic_busy_cycles: got %0d required 22", busy_cnt); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL basic_pass: got %b required 1", pass); end
    checks++; if (err_cnt !== 9'd0) begin errors++; $display("FAIL basic_err_cnt: got %0d required 0", err_cnt); end
    exp_w = 16'h0001;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (wlog[i] !== exp_w) begin errors++; $display("FAIL basic_write_word%0d: got %h required %h", i, wlog[i], exp_w); end
      exp_w = exp_w << 1;
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || pass !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_after_done: done=%b pass=%b busy=%b required 0,1,0", done, pass, busy);
    end
  endtask

  task automatic test_zero_seed();
    run(16'h0000, 8'd0, 1'b0, 20);
    checks++; if (done_cyc !== 5) begin errors++; $display("FAIL zseed_done_cycle: got %0d required 5", done_cyc); end
    checks++; if (wlog[0] !== 16'hACE1) begin errors++; $display("FAIL zseed_word0: got %h required ace1", wlog[0]); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL zseed_pass: got %b required 1", pass); end
  endtask

  task automatic test_stuck_bit();
    stuck3 = 1'b1;
    run(16'h0001, 8'd15, 1'b0, 60);
    checks++; if (done_cyc !== 35) begin errors++; $display("FAIL stuck_done_cycle: got %0d required 35", done_cyc); end
    checks++; if (err_cnt !== 9'd8) begin errors++; $display("FAIL stuck_err_cnt: got %0d required 8", err_cnt); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL stuck_pass: got %b required 0", pass); end
`ifdef RAM_BIST_FAIL_LOG_EN
    checks++; if (fail_addr !== 8'h00) begin errors++; $display("FAIL stuck_fail_addr: got %h required 00", fail_addr); end
    checks++; if (fail_data !== 16'h0100) begin errors++; $display("FAIL stuck_fail_data: got %h required 0100", fail_data); end
`else
    checks++; if (fail_addr !== 8'h00 || fail_data !== 16'h0000) begin
      errors++; $display("FAIL stuck_fail_tied: got %h/%h required 00/0000", fail_addr, fail_data); end
`endif
    stuck3 = 1'b0;
  endtask

  task automatic test_full_range();
    run(16'h1234, 8'd255, 1'b0, 600);
    checks++; if (busy_cnt !== 514) begin errors++; $display("FAIL full_busy_cycles: got %0d required 514", busy_cnt); end
    checks++; if (done_cyc !== 515) begin errors++; $display("FAIL full_done_cycle: got %0d required 515", done_cyc); end
    checks++; if (pass !== 1'b1 || err_cnt !== 9'd0) begin
      errors++; $display("FAIL full_result: pass=%b err=%0d required 1/0", pass, err_cnt); end
`ifdef RAM_BIST_FAIL_LOG_EN
    checks++; if (fail_data !== 16'h0000) begin errors++; $display("FAIL full_fail_cleared: got %h required 0000", fail_data); end
`endif
  endtask

  task automatic test_reset_mid_run();
    bit hit = 1'b0;
    @(negedge clk);
    seed = 16'h0001; last = 8'd9; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 0; c < 40 && !hit; c++) begin
      @(negedge clk);
      if (ram_oe && ram_addr == 8'd4) hit = 1'b1;
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL midrst_reach_read4: got no READ addr 4 required one"); end
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("midrst_outputs");
    rst_n = 1'b1;
    run(16'h5A5A, 8'd9, 1'b0, 40);
    checks++; if (done_cyc !== 23 || pass !== 1'b1 || err_cnt !== 9'd0) begin
      errors++; $display("FAIL midrst_rerun: done_cyc=%0d pass=%b err=%0d required 23/1/0", done_cyc, pass, err_cnt); end
  endtask

  task automatic test_back_to_back();
    int c2 = 0;
    run(16'h00FF, 8'd2, 1'b1, 20);
    checks++; if (done_cyc !== 9 || busy_cnt !== 8) begin
      errors++; $display("FAIL b2b_first_run: done_cyc=%0d busy=%0d required 9/8", done_cyc, busy_cnt); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL b2b_idle_gap: busy=%b done=%b required 0/0", busy, done); end
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_restart: busy=%b required 1", busy); end
    start = 1'b0;
    for (int c = 2; c <= 20 && c2 == 0; c++) begin
      @(negedge clk);
      if (done) c2 = c;
    end
    checks++; if (c2 !== 9 || pass !== 1'b1) begin
      errors++; $display("FAIL b2b_second_run: done_cyc=%0d pass=%b required 9/1", c2, pass); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_seed();
    test_stuck_bit();
    test_full_range();
    test_reset_mid_run();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
